// File: rtl/countdown_timer.sv
// Loadable down-counter with an IDLE/RUN control FSM and a one-cycle done pulse on expiry.
// Optional macro COUNTDOWN_AUTORELOAD_EN: on expiry, reload the last started value and keep running.
module countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state, state_next;
  logic [WIDTH-1:0] count_next;
  logic             done_next;

`ifdef COUNTDOWN_AUTORELOAD_EN
  logic [WIDTH-1:0] reload, reload_next;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      done  <= 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
      reload <= '0;
`endif
    end else begin
      state <= state_next;
      count <= count_next;
      done  <= done_next;
`ifdef COUNTDOWN_AUTORELOAD_EN
      reload <= reload_next;
`endif
    end
  end

  // Edge priority is stop > start > decrement; stop only matters while running.
  always_comb begin
    state_next = state;
    count_next = count;
    done_next  = 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
    reload_next = reload;
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
          count_next = load_val;
          if (load_val == '0) begin
            done_next = 1'b1;
          end else begin
            state_next = RUN;
`ifdef COUNTDOWN_AUTORELOAD_EN
            reload_next = load_val;
`endif
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_next = IDLE;
        end else if (start) begin
          count_next = load_val;
`ifdef COUNTDOWN_AUTORELOAD_EN
          reload_next = load_val;
`endif
          if (load_val == '0) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end
        end else if (en) begin
          if (count > ONE) begin
            count_next = count - ONE;
          end else begin
            // Expiry: count is 1 here, so the counter can never wrap below zero.
            done_next = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
            count_next = reload;
`else
            count_next = '0;
            state_next = IDLE;
`endif
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model of the timer.
module tb_countdown_timer;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             en = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  always #5 clk = ~clk;

  countdown_timer #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .stop(stop),
    .en(en),
    .load_val(load_val),
    .count(count),
    .busy(busy),
    .done(done)
  );

  // Behavioural model: remaining ticks, running flag, last started value, pulse flag.
  int m_cnt = 0;
  int m_reload = 0;
  bit m_run = 1'b0;
  bit m_done = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  // Drive one cycle of inputs at the falling edge, advance the model at the rising edge,
  // then settle 1 time unit so callers sample away from the edge.
  task automatic cycle(input logic r, input logic s, input logic p, input logic e,
                       input logic [WIDTH-1:0] lv);
    @(negedge clk);
    reset = r; start = s; stop = p; en = e; load_val = lv;
    @(posedge clk);
    m_done = 1'b0;
    if (r) begin
      m_cnt = 0; m_reload = 0; m_run = 1'b0;
    end else if (m_run && p) begin
      m_run = 1'b0;
    end else if (s) begin
      m_cnt = int'(lv);
      if (lv == 0) begin
        m_done = 1'b1;
        m_run  = 1'b0;
      end else begin
        m_reload = int'(lv);
        m_run    = 1'b1;
      end
    end else if (m_run && e) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_done = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
        m_cnt = m_reload;
`else
        m_run = 1'b0;
`endif
      end
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 0, 1, 4'd7);
    n_checks++;
    if (count !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_init: got count=%0d busy=%b done=%b, want 0 0 0", count, busy, done);
    end
    cycle(0, 1, 0, 0, 4'd9);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0);
    n_checks++;
    if (count !== 4'd6 || busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_precount: got count=%0d busy=%b, want 6 1", count, busy);
    end
    cycle(1, 0, 0, 1, 0);
    n_checks++;
    if (count !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_midcount: got count=%0d busy=%b done=%b, want 0 0 0", count, busy, done);
    end
  endtask

  task automatic test_basic();
    cycle(0, 1, 0, 1, 4'd5);
    for (int i = 0; i <= 5; i++) begin
      n_checks++;
      if (count !== m_cnt[WIDTH-1:0] || busy !== m_run || done !== m_done) begin
        n_fail++;
        $display("[TB] FAIL basic[%0d]: got count=%0d busy=%b done=%b, want count=%0d busy=%b done=%b",
                 i, count, busy, done, m_cnt, m_run, m_done);
      end
      if (i < 5) cycle(0, 0, 0, 1, 0);
    end
    cycle(0, 0, 0, 0, 0);
    n_checks++;
    if (count !== m_cnt[WIDTH-1:0] || busy !== m_run || done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL basic_after: got count=%0d busy=%b done=%b, want count=%0d busy=%b done=0",
               count, busy, done, m_cnt, m_run);
    end
  endtask

  task automatic test_gated();
    int latency;
    bit seen;
    latency = 0;
    seen = 1'b0;
    cycle(0, 1, 0, 0, 4'd3);
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle(0, 0, 0, (i % 2 == 0), 0);
      latency++;
      n_checks++;
      if (count !== m_cnt[WIDTH-1:0] || busy !== m_run || done !== m_done) begin
        n_fail++;
        $display("[TB] FAIL gated[%0d]: got count=%0d busy=%b done=%b, want count=%0d busy=%b done=%b",
                 i, count, busy, done, m_cnt, m_run, m_done);
      end
      if (done === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen || latency != 5) begin
      n_fail++;
      $display("[TB] FAIL gated_latency: got seen=%0d after %0d cycles, want done after 5", seen, latency);
    end
  endtask

  task automatic test_abort_restart();
    cycle(0, 1, 0, 0, 4'd12);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0);
    cycle(0, 1, 1, 1, 4'd3);
    n_checks++;
    if (count !== 4'd8 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL abort: got count=%0d busy=%b done=%b, want 8 0 0", count, busy, done);
    end
    cycle(0, 0, 1, 1, 0);
    n_checks++;
    if (count !== 4'd8 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL abort_hold: got count=%0d busy=%b, want 8 0", count, busy);
    end
    cycle(0, 1, 0, 0, 4'd2);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    n_checks++;
    if (done !== 1'b1 || count !== m_cnt[WIDTH-1:0] || busy !== m_run) begin
      n_fail++;
      $display("[TB] FAIL restart: got count=%0d busy=%b done=%b, want count=%0d busy=%b done=1",
               count, busy, done, m_cnt, m_run);
    end
  endtask

  task automatic test_boundaries();
    cycle(0, 0, 1, 0, 0);
    cycle(0, 1, 0, 1, 4'd0);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || count !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL zero_load: got count=%0d busy=%b done=%b, want 0 0 1", count, busy, done);
    end
    cycle(0, 0, 0, 1, 0);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL zero_pulse_width: got busy=%b done=%b, want 0 0", busy, done);
    end
    cycle(0, 1, 0, 0, 4'd6);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 1, 0, 1, 4'd7);
    n_checks++;
    if (count !== 4'd7 || busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL start_beats_tick: got count=%0d busy=%b, want 7 1", count, busy);
    end
    cycle(0, 1, 0, 1, 4'd15);
    for (int i = 1; i <= 16; i++) begin
      cycle(0, 0, 0, 1, 0);
      n_checks++;
      if (count !== m_cnt[WIDTH-1:0] || busy !== m_run || done !== m_done) begin
        n_fail++;
        $display("[TB] FAIL max_load[%0d]: got count=%0d busy=%b done=%b, want count=%0d busy=%b done=%b",
                 i, count, busy, done, m_cnt, m_run, m_done);
      end
    end
    cycle(0, 0, 1, 0, 0);
  endtask

  task automatic test_reload_pattern();
    cycle(0, 1, 0, 1, 4'd3);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, 1, 0);
      n_checks++;
      if (count !== m_cnt[WIDTH-1:0] || busy !== m_run || done !== m_done) begin
        n_fail++;
        $display("[TB] FAIL reload[%0d]: got count=%0d busy=%b done=%b, want count=%0d busy=%b done=%b",
                 i, count, busy, done, m_cnt, m_run, m_done);
      end
    end
    cycle(0, 0, 1, 1, 0);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reload_stop: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_random();
    logic r, s, p, e;
    logic [WIDTH-1:0] lv;
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 99) < 2);
      s  = ($urandom_range(0, 99) < 12);
      p  = ($urandom_range(0, 99) < 6);
      e  = ($urandom_range(0, 99) < 70);
      lv = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      cycle(r, s, p, e, lv);
      n_checks++;
      if (count !== m_cnt[WIDTH-1:0] || busy !== m_run || done !== m_done) begin
        n_fail++;
        $display("[TB] FAIL random[%0d]: got count=%0d busy=%b done=%b, want count=%0d busy=%b done=%b",
                 i, count, busy, done, m_cnt, m_run, m_done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gated();
    test_abort_restart();
    test_boundaries();
    test_reload_pattern();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
